// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter (double dabble, one bit per clock)
//
// Purpose:
//   Converts an unsigned IN_W-bit binary value into DIGITS packed BCD digits
//   using shift-add-3, one input bit per clock, with a start/done handshake.
//   Results larger than 10^DIGITS-1 saturate to all 9s and raise ovf.
//
// Parameters:
//   IN_W    binary input width in bits (>=1)
//   DIGITS  number of BCD output digits (>=1)
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   conversion request, sampled only while idle
//   bin    in   [IN_W-1:0] value captured on an accepted start
//   busy   out  conversion in progress
//   done   out  one-cycle pulse, bcd/ovf updated in the same cycle
//   bcd    out  [4*DIGITS-1:0] result, digit 0 (units) in [3:0]
//   ovf    out  last result exceeded 10^DIGITS-1
//
// Build option:
//   BIN2BCD_BLANK_EN  when defined, leading zero digits above digit 0 are
//                     output as 4'hF (blank code); saturated results are
//                     never blanked.

module bin2bcd_seq #(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);
  localparam logic [SW-1:0] ALL9 = {DIGITS{4'h9}};

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q;
  logic [IN_W-1:0] sh_q;
  logic [SW-1:0]   scr_q;
  logic [CW-1:0]   cnt_q;
  logic            sticky_q;
  logic            busy_q;
  logic            done_q;
  logic [SW-1:0]   bcd_q;
  logic            ovf_q;

  logic [SW-1:0]   adj;
  logic [SW-1:0]   scr_d;
  logic [IN_W-1:0] sh_d;
  logic            sticky_d;
  logic [SW-1:0]   fmt_d;

  // Add-3 correction: any digit >= 5 would become >= 10 after doubling.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // {scratch, shiftreg} shifted left by one; the MSB of the adjusted top digit
  // falls off the end, which happens exactly when the running value reaches
  // 10^DIGITS, so it is captured as a sticky overflow.
  assign scr_d    = {adj[SW-2:0], sh_q[IN_W-1]};
  assign sh_d     = sh_q << 1;
  assign sticky_d = sticky_q | adj[SW-1];

`ifdef BIN2BCD_BLANK_EN
  // Replace leading zero digits (never digit 0) with the blank code 4'hF.
  function automatic logic [SW-1:0] blank_lz(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          lead;
    r    = v;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'h0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  assign fmt_d = blank_lz(scr_d);
`else
  assign fmt_d = scr_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_q     <= bin;
            scr_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= CW'(IN_W);
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q     <= sh_d;
          scr_q    <= scr_d;
          sticky_q <= sticky_d;
          cnt_q    <= cnt_q - CW'(1);
          // Last bit: publish the result in the same edge as the shift.
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ovf_q   <= sticky_d;
            bcd_q   <= sticky_d ? ALL9 : fmt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq

module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance A: defaults (6 bits, 2 digits)
  logic        start_a = 1'b0;
  logic [5:0]  bin_a   = '0;
  logic        busy_a, done_a, ovf_a;
  logic [7:0]  bcd_a;

  // Instance B: 10 bits, 2 digits
  logic        start_b = 1'b0;
  logic [9:0]  bin_b   = '0;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;

  // Instance C: 10 bits, 3 digits
  logic        start_c = 1'b0;
  logic [9:0]  bin_c   = '0;
  logic        busy_c, done_c, ovf_c;
  logic [11:0] bcd_c;

  bin2bcd_seq #(.IN_W(6), .DIGITS(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
  );

  bin2bcd_seq #(.IN_W(10), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b)
  );

  bin2bcd_seq #(.IN_W(10), .DIGITS(3)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .ovf(ovf_c)
  );

  int checks = 0;
  int errors = 0;
  int sel_v  = 0;

  logic        busy_m, done_m, ovf_m;
  logic [11:0] bcd_m;

  always_comb begin
    busy_m = busy_a;
    done_m = done_a;
    ovf_m  = ovf_a;
    bcd_m  = {4'h0, bcd_a};
    case (sel_v)
      1: begin busy_m = busy_b; done_m = done_b; ovf_m = ovf_b; bcd_m = {4'h0, bcd_b}; end
      2: begin busy_m = busy_c; done_m = done_c; ovf_m = ovf_c; bcd_m = bcd_c; end
      default: ;
    endcase
  end

  function automatic int inw_of(input int sel);
    return (sel == 0) ? 6 : 10;
  endfunction

  function automatic int digits_of(input int sel);
    return (sel == 2) ? 3 : 2;
  endfunction

  // Reference: {ovf, bcd} from decimal arithmetic on the integer value.
  function automatic logic [12:0] model(input int digits, input int val);
    logic [11:0] r;
    logic        o;
    int          lim;
    int          v;
    int          p;
    r   = '0;
    o   = 1'b0;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (val >= lim) begin
      o = 1'b1;
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
    end else begin
      v = val;
      for (int i = 0; i < digits; i++) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
`ifdef BIN2BCD_BLANK_EN
      p = 1;
      for (int i = 1; i < digits; i++) begin
        p = p * 10;
        if (val < p) r[4*i +: 4] = 4'hF;
      end
`else
      p = 0;
`endif
    end
    return {o, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input int val);
    case (sel)
      0: begin start_a = s; bin_a = val[5:0]; end
      1: begin start_b = s; bin_b = val[9:0]; end
      default: begin start_c = s; bin_c = val[9:0]; end
    endcase
  endtask

  // Starts a conversion at posedge+1 and returns in the done cycle.
  task automatic conv(input int sel, input int val);
    int          n;
    logic [12:0] e;
    sel_v = sel;
    drive(sel, 1'b1, val);
    @(posedge clk); #1;
    drive(sel, 1'b0, val);
    n = 0;
    while (done_m !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    e = model(digits_of(sel), val);
    check("latency", n, inw_of(sel));
    check("done", done_m, 1);
    check("busy_at_done", busy_m, 0);
    check("bcd", bcd_m, e[11:0]);
    check("ovf", ovf_m, e[12]);
  endtask

  initial begin
    int          dcount;
    logic [11:0] held;
    logic [12:0] e;

    // Reset state
    #2;
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_bcd_a", bcd_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_bcd_c", bcd_c, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 59, then hold
    conv(0, 59);
    held = bcd_m;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("done_pulse_end", done_m, 0);
      check("bcd_hold", bcd_m, held);
    end

    // 63, then 0 started in the done cycle
    conv(0, 63);
    conv(0, 0);
    @(posedge clk); #1;

    // Overflow and wide cases
    conv(1, 100);
    conv(2, 999);
    conv(2, 1023);
    conv(2, 7);
    conv(2, 0);
    conv(2, 305);
    conv(2, 1000);
    conv(1, 99);
    conv(0, 1);

    // start while busy is ignored
    sel_v = 0;
    drive(0, 1'b1, 42);
    @(posedge clk); #1;
    drive(0, 1'b0, 42);
    @(posedge clk); #1;
    drive(0, 1'b1, 17);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_mid", busy_a, 1);
    drive(0, 1'b0, 17);
    dcount = 0;
    held   = '0;
    for (int i = 0; i < 12; i++) begin
      if (done_a === 1'b1) begin
        dcount++;
        held = {4'h0, bcd_a};
      end
      @(posedge clk); #1;
    end
    check("single_done", dcount, 1);
    e = model(2, 42);
    check("bcd_42", held, e[11:0]);

    // Asynchronous reset mid-conversion
    drive(0, 1'b1, 45);
    @(posedge clk); #1;
    drive(0, 1'b0, 45);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_done", done_a, 0);
    check("arst_bcd", bcd_a, 0);
    check("arst_ovf", ovf_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) dcount++;
    end
    check("no_done_after_abort", dcount, 0);
    conv(0, 12);

    // Randomised conversions on all instances
    for (int k = 0; k < 20; k++) begin
      conv(0, int'($urandom_range(0, 63)));
      conv(1, int'($urandom_range(0, 1023)));
      conv(2, int'($urandom_range(0, 1023)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using iterative shift-add-3 (double dabble), one input bit per clock.
- Generalises the fixed 0..59 tens/units splitter to any input width and digit count, and adds a start/done handshake and overflow saturation.
- Sits between the clock's binary counters (seconds/minutes/hours, alarm values) and the seven-segment digit decoders.

Parameters:
IN_W, 6, binary input width in bits (>=1)
DIGITS, 2, number of BCD output digits (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion; sampled only when busy=0
bin  input  IN_W  unsigned binary value, captured on accepted start
busy  output  1  conversion in progress
done  output  1  one-cycle pulse; bcd/ovf valid and updated
bcd  output  4*DIGITS  result, digit 0 (units) in bits [3:0], digit i in [4i+3:4i]
ovf  output  1  last result exceeded 10^DIGITS-1

Behaviour:
- Reset (async, any time): busy=0, done=0, bcd=0, ovf=0, internal shift/scratch/counter registers=0, FSM=IDLE. A conversion in flight is aborted with no done pulse.
- FSM states: IDLE, SHIFT.
- IDLE: on the edge where start=1, capture bin into the shift register, clear the BCD scratch, clear the sticky overflow flag, load bit counter=IN_W, go to SHIFT, busy=1. done is cleared on every edge not completing a conversion.
- SHIFT, one bit per edge: every scratch digit >=5 gets +3, then {scratch, shiftreg} shifts left by 1 (MSB of bin enters digit 0 LSB). Any 1 shifted out of the top digit's MSB sets the sticky overflow flag. Counter decrements.
- On the edge performing the IN_W-th shift: FSM->IDLE, busy=0, done=1 for exactly one cycle, ovf=sticky flag. bcd=final scratch if no overflow, else all digits 4'h9 (saturate).
- Latency: start sampled at edge 0; done, bcd and ovf visible after edge IN_W. Back-to-back throughput: one conversion per IN_W+1 cycles. A start sampled while done=1 is accepted.
- start while busy=1 is ignored; bin is not re-sampled; the in-flight result is unaffected.
- bcd and ovf hold their values between done pulses. They change only on done or on reset.
- Counter width: $clog2(IN_W+1). Scratch width: 4*DIGITS.
- Every digit of a non-overflow result is 0..9. Input 0 yields bcd=0 and ovf=0.
- IN_W=1 is legal: latency 1 cycle.

Optional Feature:
Macro BIN2BCD_BLANK_EN.
- Defined: leading-zero blanking on the bcd output. Every digit above digit 0 that is 0, with all higher digits also 0, is output as 4'hF (the decoders' blank code). Digit 0 is never blanked. Blanking is applied in the same register load as done, so latency is unchanged. A saturated overflow result (all 9s) is never blanked.
- Undefined: bcd is the plain BCD value including leading zeros. The port list is identical in both builds.

Test Plan:
- Defaults, bin=59, start pulse -> after 6 edges done=1 for 1 cycle, bcd=8'h59, ovf=0, busy=0. bcd stays 8'h59 afterwards.
- Defaults, bin=63, then bin=0 started in the done cycle -> bcd=8'h63, then 7 edges later bcd=8'h00. ovf=0 both times.
- IN_W=10, DIGITS=2, bin=100 -> done after 10 edges, ovf=1, bcd=8'h99. IN_W=10, DIGITS=3, bin=999 -> bcd=12'h999, ovf=0. bin=1023 with DIGITS=3 -> ovf=1, bcd=12'h999.
- Defaults, bin=42 started, start re-asserted with bin=17 on edges 2 and 3 -> single done, bcd=8'h42. No second conversion starts.
- Defaults, bin=45 started, rst pulsed at edge 3 -> busy/done/bcd/ovf=0 immediately (asynchronously), no done pulse. Next start with bin=12 -> bcd=8'h12.
- BIN2BCD_BLANK_EN defined, DIGITS=3, IN_W=10: bin=7 -> 12'hFF7; bin=0 -> 12'hFF0; bin=305 -> 12'h305; bin=1000 -> 12'h999 with ovf=1.
